// File: rtl/nonce_scheduler.sv
// nonce_scheduler: walks an inclusive nonce range through an external hash core
// and stops at the first nonce whose hash is strictly below the target.
// Optional feature macro: WATCHDOG_EN. When it is defined, a WAIT-cycle counter
// raises error if the core does not answer within TIMEOUT_CYC cycles.
module nonce_scheduler #(
    parameter int NONCE_W     = 32,
    parameter int HASH_W      = 256,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_first,
    input  logic [NONCE_W-1:0] nonce_last,
    input  logic [HASH_W-1:0]  target,
    output logic               core_start,
    output logic [NONCE_W-1:0] core_nonce,
    input  logic               core_done,
    input  logic [HASH_W-1:0]  core_hash,
    output logic               busy,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic               exhausted,
    output logic               error
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        CHECK   = 3'd4,
        TIMEOUT = 3'd5
    } state_t;

    state_t state, nxt;

    logic [NONCE_W-1:0] first_q, last_q, cur_q, fnonce_q;
    logic [HASH_W-1:0]  target_q, hash_q;
    logic               found_q, exh_q;

    // control strobes from the FSM into the datapath
    logic ld_range, ld_cur, inc_cur, cap_hash, set_found, set_exh;

`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;
    logic            err_q, wd_clr, wd_inc, set_err;
`else
    // TIMEOUT_CYC only matters when the watchdog is built in.
    if (TIMEOUT_CYC < 1) begin : g_timeout_unused
    end
`endif

    // state register; synchronous reset wins over everything
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // next state, strobes and busy/core_start; abort beats core_done and CHECK
    always_comb begin
        nxt        = state;
        ld_range   = 1'b0;
        ld_cur     = 1'b0;
        inc_cur    = 1'b0;
        cap_hash   = 1'b0;
        set_found  = 1'b0;
        set_exh    = 1'b0;
        core_start = 1'b0;
        busy       = 1'b0;
`ifdef WATCHDOG_EN
        wd_clr     = 1'b0;
        wd_inc     = 1'b0;
        set_err    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    nxt      = LOAD;
                    ld_range = 1'b1;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (abort) begin
                    nxt = IDLE;
                end else if (first_q > last_q) begin
                    set_exh = 1'b1;
                    nxt     = IDLE;
                end else begin
                    ld_cur = 1'b1;
                    nxt    = ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (abort) begin
                    nxt = IDLE;
                end else begin
                    core_start = 1'b1;
                    nxt        = WAIT;
`ifdef WATCHDOG_EN
                    wd_clr     = 1'b1;
`endif
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (abort) begin
                    nxt = IDLE;
                end else if (core_done) begin
                    cap_hash = 1'b1;
                    nxt      = CHECK;
`ifdef WATCHDOG_EN
                end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    set_err = 1'b1;
                    nxt     = TIMEOUT;
                end else begin
                    wd_inc = 1'b1;
`endif
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (abort) begin
                    nxt = IDLE;
                end else if (hash_q < target_q) begin
                    set_found = 1'b1;
                    nxt       = IDLE;
                end else if (cur_q == last_q) begin
                    set_exh = 1'b1;
                    nxt     = IDLE;
                end else begin
                    inc_cur = 1'b1;
                    nxt     = ISSUE;
                end
            end
`ifdef WATCHDOG_EN
            TIMEOUT: nxt = IDLE;
`endif
            default: nxt = IDLE;
        endcase
    end

    // range/target latch, nonce walker, captured hash and result flags
    always_ff @(posedge clock) begin
        if (reset) begin
            first_q  <= '0;
            last_q   <= '0;
            target_q <= '0;
            cur_q    <= '0;
            hash_q   <= '0;
            found_q  <= 1'b0;
            fnonce_q <= '0;
            exh_q    <= 1'b0;
        end else begin
            if (ld_range) begin
                first_q  <= nonce_first;
                last_q   <= nonce_last;
                target_q <= target;
                found_q  <= 1'b0;
                exh_q    <= 1'b0;
            end
            if (ld_cur)   cur_q  <= first_q;
            if (inc_cur)  cur_q  <= cur_q + 1'b1;
            if (cap_hash) hash_q <= core_hash;
            if (set_found) begin
                found_q  <= 1'b1;
                fnonce_q <= cur_q;
            end
            if (set_exh)  exh_q  <= 1'b1;
        end
    end

`ifdef WATCHDOG_EN
    // WAIT-cycle counter and sticky timeout flag
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (ld_range)    err_q <= 1'b0;
            if (set_err)     err_q <= 1'b1;
            if (wd_clr)      wd_q  <= '0;
            else if (wd_inc) wd_q  <= wd_q + 1'b1;
        end
    end
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    assign core_nonce  = cur_q;
    assign found       = found_q;
    assign found_nonce = fnonce_q;
    assign exhausted   = exh_q;

endmodule

// File: doc/nonce_scheduler.md
NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 The block SHALL have parameter NONCE_W, default 32, meaning nonce width in bits.
REQ-002 The block SHALL have parameter HASH_W, default 256, meaning hash and target width in bits.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1024, meaning the watchdog limit in WAIT cycles (used only under WATCHDOG_EN).
REQ-004 The block SHALL have these ports:
  clock  in  1  rising-edge clock
  reset  in  1  reset, synchronous, active-high
  start  in  1  launch request, sampled only in IDLE
  abort  in  1  cancel the run in progress
  nonce_first  in  NONCE_W  first nonce of the range
  nonce_last  in  NONCE_W  last nonce of the range, inclusive
  target  in  HASH_W  difficulty threshold
  core_start  out  1  one-cycle launch pulse to the hash core
  core_nonce  out  NONCE_W  nonce presented to the core
  core_done  in  1  hash core result valid, one-cycle pulse
  core_hash  in  HASH_W  hash core result
  busy  out  1  run in progress
  found  out  1  sticky flag: a winning nonce was found
  found_nonce  out  NONCE_W  the winning nonce
  exhausted  out  1  sticky flag: range completed with no winner
  error  out  1  sticky flag: watchdog timeout

Function
REQ-005 The FSM SHALL have states IDLE, LOAD, ISSUE, WAIT, CHECK and TIMEOUT, held in a 3-bit register.
REQ-006 IDLE with start=1 SHALL go to LOAD, latch nonce_first, nonce_last and target, and clear found, exhausted and error.
REQ-007 LOAD SHALL set cur_nonce to latched nonce_first and go to ISSUE; if first > last (unsigned), it SHALL set exhausted and return to IDLE without issuing to the core.
REQ-008 ISSUE SHALL assert core_start for exactly one cycle with core_nonce = cur_nonce, then go to WAIT.
REQ-009 WAIT SHALL hold until core_done=1, capture core_hash, then go to CHECK; core_done in any other state SHALL be ignored.
REQ-010 CHECK SHALL test core_hash < target (unsigned, strict), then act as follows.
  Hit: set found, set found_nonce = cur_nonce, go to IDLE.
  Miss with cur_nonce == last: set exhausted, go to IDLE.
  Otherwise: increment cur_nonce by 1, go to ISSUE.
REQ-011 cur_nonce SHALL never wrap; a range ending at all-ones SHALL terminate via the equality test, with no increment.
REQ-012 busy SHALL be 1 in LOAD, ISSUE, WAIT and CHECK, and 0 in IDLE.
REQ-013 start while busy SHALL be ignored.
REQ-014 abort=1 in any busy state SHALL force IDLE on the next edge, leave found, exhausted and error unchanged at 0, and suppress core_start.
REQ-015 abort SHALL take priority over core_done and over the CHECK outcome.
REQ-016 Latency SHALL be: start sampled at edge k puts ISSUE after edge k+1, with core_start high in the following cycle; each subsequent nonce costs 3 cycles plus core latency.
REQ-017 found_nonce SHALL hold its value until the next accepted start.
REQ-018 core_nonce SHALL equal cur_nonce at all times.

Reset
REQ-019 Reset SHALL have priority over all inputs.
REQ-020 Reset SHALL set state=IDLE; core_start, busy, found, exhausted and error to 0; and cur_nonce, found_nonce, latched range and target to 0.
REQ-021 Reset mid-run SHALL abandon the run; a later core_done SHALL be ignored.
REQ-022 An unknown state encoding SHALL recover to IDLE on the next edge.

Configuration
REQ-023 With macro WATCHDOG_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-024 Under WATCHDOG_EN, reaching TIMEOUT_CYC without core_done SHALL go to TIMEOUT, which sets error for one cycle then returns to IDLE, with busy=0.
REQ-025 Under WATCHDOG_EN, core_done in the same cycle the limit is reached SHALL win over the timeout.
REQ-026 Without WATCHDOG_EN, no counter or TIMEOUT logic SHALL exist, error SHALL be tied 0, and WAIT SHALL wait indefinitely.

Verification
REQ-027 Range 5..9, target such that the hash for nonce 7 is below target -> core_start pulses for 5, 6, 7, then found=1, found_nonce=7, exhausted=0.
REQ-028 Range 0..3, all hashes >= target -> 4 core_start pulses, then exhausted=1, found=0, busy=0.
REQ-029 Range FFFFFFFE..FFFFFFFF, no hit -> 2 pulses, exhausted=1, no third pulse; and first=10, last=3 -> exhausted=1 with zero pulses.
REQ-030 abort during WAIT of nonce 2 together with core_done and a winning hash -> IDLE next cycle, found=0, no further core_start.
REQ-031 Under WATCHDOG_EN with TIMEOUT_CYC=16 and core_done never asserted -> error=1 after 16 WAIT cycles, busy=0; a new start clears error.
